i2c_slave_reg_ctrl: RTL and testbench

Register-file controller that sequences the I2C slave byte datapath into a standard pointer-addressed register map.
- Write transaction: the first data byte after START or repeated START sets the register pointer; subsequent bytes write consecutive registers.
- Read transaction: the slave is fed from consecutive registers.
- A fabric-side host port lets the rest of the design load status registers and observe I2C writes.
- Sits between the I2C slave (datareceive/received/datasend/sended plus start/stop pulses) and application logic.

---
 rtl/i2c_slave_reg_ctrl_pkg.sv | 17 +
 rtl/i2c_slave_reg_ctrl_if.sv | 42 ++++
 rtl/i2c_slave_reg_ctrl_edge_rise.sv | 25 ++
 rtl/i2c_slave_reg_ctrl.sv | 154 +++++++++++++++
 tb/tb_i2c_slave_reg_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_reg_ctrl_pkg.sv
// Shared types and constants for the I2C slave register-map controller.
// The controller FSM walks IDLE -> PTR (waiting for the pointer byte)
// -> DATA (consecutive register accesses) and back to IDLE on STOP.
package i2c_slave_reg_ctrl_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_PTR  = 2'd1,
        CTRL_DATA = 2'd2
    } ctrl_state_t;

    // Byte-wide utility constants used for clears and pointer stepping.
    localparam logic [7:0] ZERO8 = 8'h00;
    localparam logic [7:0] ONE8  = 8'h01;

endpackage

// File: rtl/i2c_slave_reg_ctrl_if.sv
// Bundle of every signal between the register controller and its
// surroundings: the I2C slave byte datapath, the fabric host write port
// and the observation outputs (write strobe, register image, pointer).
// The controller uses the slave modport; the driving side uses master.
interface i2c_slave_reg_ctrl_if #(
    parameter int PTR_W = 4
);
    localparam int NREG = 1 << PTR_W;

    // I2C slave byte datapath.
    logic               i2c_start;
    logic               i2c_stop;
    logic [7:0]         datareceive;
    logic               received;
    logic               sended;
    logic [7:0]         datasend;

    // Fabric host write port.
    logic               host_we;
    logic [PTR_W-1:0]   host_addr;
    logic [7:0]         host_data;

    // Observation of I2C writes and register state.
    logic               wr_strobe;
    logic [PTR_W-1:0]   wr_addr;
    logic [7:0]         wr_data;
    logic [8*NREG-1:0]  regs_flat;
    logic [PTR_W-1:0]   ptr;

    modport master (
        output i2c_start, i2c_stop, datareceive, received, sended,
        output host_we, host_addr, host_data,
        input  datasend, wr_strobe, wr_addr, wr_data, regs_flat, ptr
    );

    modport slave (
        input  i2c_start, i2c_stop, datareceive, received, sended,
        input  host_we, host_addr, host_data,
        output datasend, wr_strobe, wr_addr, wr_data, regs_flat, ptr
    );

endinterface

// File: rtl/i2c_slave_reg_ctrl_edge_rise.sv
// Registered rising-edge detector. The slave's received/sended flags are
// levels that may stay high for many clocks; this turns each low-to-high
// transition into a single-clock event.
module i2c_edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_d;

    // One-clock history of the level, cleared so a level already high
    // coming out of reset still produces one event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// Pointer-addressed register file sitting behind an I2C slave.
// After START the first received byte loads the register pointer, later
// received bytes write consecutive registers (unless read-only), and each
// transmit request advances the pointer so reads stream consecutive
// registers. A fabric host port can load any register, including
// read-only status registers, without touching the pointer or the FSM.
module i2c_slave_reg_ctrl
    import i2c_slave_reg_ctrl_pkg::*;
#(
    parameter int                        PTR_W    = 4,
    parameter logic [(1 << PTR_W)-1:0]   RO_MASK  = '0,
    parameter bit                        AUTO_INC = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_slave_reg_ctrl_if.slave  bus
);

    localparam int               NREG = 1 << PTR_W;
    localparam logic [PTR_W-1:0] INC  = PTR_W'(AUTO_INC ? ONE8 : ZERO8);

    ctrl_state_t        state_q;
    ctrl_state_t        state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic               i2c_we;
    logic               rx_evt;
    logic               tx_evt;

    logic [7:0]         regs_q [NREG];
    logic [7:0]         regs_d [NREG];
    logic [8*NREG-1:0]  regs_flat_w;

    logic [7:0]         datasend_q;
    logic               wr_strobe_q;
    logic [PTR_W-1:0]   wr_addr_q;
    logic [7:0]         wr_data_q;

    i2c_edge_rise u_rx_edge (
        .clk   (clk),
        .reset (reset),
        .level (bus.received),
        .rise  (rx_evt)
    );

    i2c_edge_rise u_tx_edge (
        .clk   (clk),
        .reset (reset),
        .level (bus.sended),
        .rise  (tx_evt)
    );

    // FSM state and register pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CTRL_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state, next pointer and I2C write enable; START beats STOP, and
    // both drop any byte event in the same clock. A stray tx_evt coinciding
    // with rx_evt is absorbed by the rx branch so the pointer moves once.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        i2c_we  = 1'b0;
        if (bus.i2c_start) begin
            state_d = CTRL_PTR;
        end else if (bus.i2c_stop) begin
            state_d = CTRL_IDLE;
        end else if (rx_evt) begin
            case (state_q)
                CTRL_PTR: begin
                    ptr_d   = bus.datareceive[PTR_W-1:0];
                    state_d = CTRL_DATA;
                end
                CTRL_DATA: begin
                    i2c_we = ~RO_MASK[ptr_q];
                    ptr_d  = ptr_q + INC;
                end
                default: begin
                end
            endcase
        end else if (tx_evt && (state_q != CTRL_IDLE)) begin
            ptr_d = ptr_q + INC;
        end
    end

    // Next register contents; the I2C write is applied last so it wins a
    // same-address collision with the host port.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (bus.host_we) begin
            regs_d[bus.host_addr] = bus.host_data;
        end
        if (i2c_we) begin
            regs_d[ptr_q] = bus.datareceive;
        end
    end

    // Register file storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= ZERO8;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Transmit byte tracks the next pointer and next register contents so
    // it is ready one clock after any pointer move or write; the write
    // strobe and its address/data are registered alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            datasend_q  <= ZERO8;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= ZERO8;
        end else begin
            datasend_q  <= regs_d[ptr_d];
            wr_strobe_q <= i2c_we;
            if (i2c_we) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= bus.datareceive;
            end
        end
    end

    // Flatten the register array into the exported image.
    always_comb begin
        regs_flat_w = '0;
        for (int i = 0; i < NREG; i++) begin
            regs_flat_w[8*i +: 8] = regs_q[i];
        end
    end

    assign bus.regs_flat = regs_flat_w;
    assign bus.ptr       = ptr_q;
    assign bus.datasend  = datasend_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Bench for the I2C slave register controller. Stimulus tasks push the
// expected write strobes and transmit bytes into queues; a monitor
// running alongside pops and compares whenever the controller pulses
// wr_strobe or the emulated slave raises sended. Register image and
// pointer are compared against a bench-side register model.
module tb_i2c_slave_reg_ctrl;

    localparam int PTR_W = 4;
    localparam int NREG  = 1 << PTR_W;

    typedef enum {S_START, S_STOP, S_RX, S_TX} stim_t;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    logic [11:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  exp_regs [NREG];

    i2c_slave_reg_ctrl_if #(.PTR_W(PTR_W)) bus ();

    i2c_slave_reg_ctrl #(
        .PTR_W    (PTR_W),
        .RO_MASK  (16'h8000),
        .AUTO_INC (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] modelFlat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < NREG; i++) begin
            f[8*i +: 8] = exp_regs[i];
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input stim_t kind, input logic [7:0] value);
        case (kind)
            S_START: begin
                bus.i2c_start = 1'b1; tick(); bus.i2c_start = 1'b0; tick();
            end
            S_STOP: begin
                bus.i2c_stop = 1'b1; tick(); bus.i2c_stop = 1'b0; tick();
            end
            S_RX: begin
                bus.datareceive = value;
                bus.received = 1'b1; tick(); tick();
                bus.received = 1'b0; tick(); tick();
            end
            S_TX: begin
                bus.sended = 1'b1; tick(); tick();
                bus.sended = 1'b0; tick(); tick();
            end
            default: begin
            end
        endcase
    endtask

    task automatic rxWrite(input logic [3:0] addr, input logic [7:0] data);
        wr_q.push_back({addr, data});
        exp_regs[addr] = data;
        applyStimulus(S_RX, data);
    endtask

    task automatic txRead(input logic [7:0] expected);
        rd_q.push_back(expected);
        applyStimulus(S_TX, 8'h00);
    endtask

    task automatic hostWrite(input logic [3:0] addr, input logic [7:0] data);
        bus.host_addr = addr;
        bus.host_data = data;
        bus.host_we   = 1'b1;
        tick();
        bus.host_we   = 1'b0;
        exp_regs[addr] = data;
    endtask

    // I2C data byte and host write landing on the same clock edge.
    task automatic collide(input logic [3:0] i2c_addr, input logic [7:0] i2c_data,
                           input logic [3:0] h_addr, input logic [7:0] h_data);
        wr_q.push_back({i2c_addr, i2c_data});
        bus.datareceive = i2c_data;
        bus.received    = 1'b1;
        bus.host_addr   = h_addr;
        bus.host_data   = h_data;
        bus.host_we     = 1'b1;
        tick();
        bus.host_we     = 1'b0;
        tick();
        bus.received    = 1'b0;
        tick(); tick();
        exp_regs[h_addr]   = h_data;
        exp_regs[i2c_addr] = i2c_data;
    endtask

    task automatic monitorLoop();
        logic        prev_sended;
        logic [11:0] w;
        logic [7:0]  r;
        prev_sended = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wr_strobe === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checkOutput("wr_strobe_unexpected", 128'(bus.wr_strobe), 128'(1'b0));
                end else begin
                    w = wr_q.pop_front();
                    checkOutput("wr_addr_data", 128'({bus.wr_addr, bus.wr_data}), 128'(w));
                end
            end
            if (bus.sended && !prev_sended && rd_q.size() != 0) begin
                r = rd_q.pop_front();
                checkOutput("datasend", 128'(bus.datasend), 128'(r));
            end
            prev_sended = bus.sended;
        end
    endtask

    // Watchdog so the run always ends even if stimulus stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios in sequence.
    initial begin
        reset           = 1'b1;
        bus.i2c_start   = 1'b0;
        bus.i2c_stop    = 1'b0;
        bus.datareceive = 8'h00;
        bus.received    = 1'b0;
        bus.sended      = 1'b0;
        bus.host_we     = 1'b0;
        bus.host_addr   = '0;
        bus.host_data   = 8'h00;
        for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;

        fork
            monitorLoop();
        join_none

        tick(); tick();
        checkOutput("reset_ptr", 128'(bus.ptr), 128'(0));
        checkOutput("reset_datasend", 128'(bus.datasend), 128'(0));
        checkOutput("reset_regs", bus.regs_flat, 128'(0));
        checkOutput("reset_wr_strobe", 128'(bus.wr_strobe), 128'(0));
        reset = 1'b0;
        tick();

        // Write burst: pointer 3, then two data bytes, then STOP.
        applyStimulus(S_START, 8'h00);
        applyStimulus(S_RX, 8'h03);
        rxWrite(4'd3, 8'hA5);
        rxWrite(4'd4, 8'h5A);
        applyStimulus(S_STOP, 8'h00);
        checkOutput("burst_ptr", 128'(bus.ptr), 128'(5));
        applyStimulus(S_RX, 8'h66);
        checkOutput("idle_ptr_hold", 128'(bus.ptr), 128'(5));
        checkOutput("burst_regs", bus.regs_flat, modelFlat());

        // Pointer set, repeated START, three reads.
        hostWrite(4'd2, 8'h11);
        hostWrite(4'd3, 8'h22);
        hostWrite(4'd4, 8'h33);
        applyStimulus(S_START, 8'h00);
        applyStimulus(S_RX, 8'h02);
        applyStimulus(S_START, 8'h00);
        txRead(8'h11);
        txRead(8'h22);
        txRead(8'h33);
        checkOutput("read_ptr", 128'(bus.ptr), 128'(5));
        applyStimulus(S_STOP, 8'h00);

        // Wrap through the read-only top register.
        hostWrite(4'd15, 8'hF0);
        applyStimulus(S_START, 8'h00);
        applyStimulus(S_RX, 8'hFE);
        rxWrite(4'd14, 8'h77);
        applyStimulus(S_RX, 8'h88);
        rxWrite(4'd0, 8'h99);
        applyStimulus(S_STOP, 8'h00);
        checkOutput("wrap_ptr", 128'(bus.ptr), 128'(1));
        checkOutput("wrap_regs", bus.regs_flat, modelFlat());

        // Host/I2C collisions: same address then different addresses.
        applyStimulus(S_START, 8'h00);
        applyStimulus(S_RX, 8'h05);
        collide(4'd5, 8'hAA, 4'd5, 8'hBB);
        applyStimulus(S_START, 8'h00);
        applyStimulus(S_RX, 8'h04);
        collide(4'd4, 8'h44, 4'd6, 8'hCC);
        applyStimulus(S_STOP, 8'h00);
        checkOutput("collide_ptr", 128'(bus.ptr), 128'(5));
        checkOutput("collide_regs", bus.regs_flat, modelFlat());

        // Received held high for 50 clocks gives one write.
        applyStimulus(S_START, 8'h00);
        applyStimulus(S_RX, 8'h07);
        wr_q.push_back({4'd7, 8'h42});
        exp_regs[7] = 8'h42;
        bus.datareceive = 8'h42;
        bus.received = 1'b1;
        repeat (50) tick();
        bus.received = 1'b0;
        tick(); tick();
        applyStimulus(S_STOP, 8'h00);
        checkOutput("hold_ptr", 128'(bus.ptr), 128'(8));
        checkOutput("hold_regs", bus.regs_flat, modelFlat());

        // Asynchronous reset between pointer byte and data byte.
        applyStimulus(S_START, 8'h00);
        applyStimulus(S_RX, 8'h09);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_ptr", 128'(bus.ptr), 128'(0));
        checkOutput("async_reset_datasend", 128'(bus.datasend), 128'(0));
        checkOutput("async_reset_regs", bus.regs_flat, 128'(0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;
        applyStimulus(S_RX, 8'h12);
        checkOutput("post_reset_ptr", 128'(bus.ptr), 128'(0));
        checkOutput("post_reset_regs", bus.regs_flat, modelFlat());

        repeat (4) tick();
        checkOutput("pending_writes", 128'(wr_q.size()), 128'(0));
        checkOutput("pending_reads", 128'(rd_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
